instr_encoder_loader: RTL and testbench

Inverse of the instruction decode stage: accepts decoded instruction fields over a valid/ready stream, packs them into 16-bit instruction words and writes them sequentially into instruction memory. Sits between a boot/debug host (or test harness) and the instruction memory write port; runs only while a load session is active. A small FIFO decouples field input from memory write backpressure.

---
 rtl/instr_encoder_loader_if.sv | 28 ++
 rtl/instr_encoder_loader.sv | 138 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Field-stream and instruction-memory write-port signals of the encoder/loader.
// The loader is the slave on the field stream and drives the memory port;
// the master modport is the host/memory side.
interface instr_encoder_loader_if #(
  parameter int IMEM_AW = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [4:0]         in_opcode;
  logic [2:0]         in_rd;
  logic [2:0]         in_rs1;
  logic [2:0]         in_rs2;
  logic [4:0]         in_address;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [15:0]        imem_wdata;
  logic               imem_ready;

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_address, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_address, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: packs decoded instruction fields into 16-bit
// words, buffers them in a small FIFO and writes them to consecutive
// instruction-memory addresses during a start..finish load session.
module instr_encoder_loader #(
  parameter int IMEM_AW    = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IMEM_AW-1:0]    base_addr,
  input  logic                  finish,
  instr_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic [IMEM_AW:0]      word_count,
  output logic                  err_illegal,
  output logic                  err_wrap
);

  localparam int                 PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0]        FULL_CNT  = (PW+1)'(FIFO_DEPTH);
  localparam logic [IMEM_AW:0]   WC_MAX    = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [IMEM_AW-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t             state_q;
  logic [15:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      rd_ptr_q;
  logic [PW:0]        cnt_q;
  logic [PW:0]        cnt_d;
  logic [IMEM_AW-1:0] addr_q;
  logic [IMEM_AW:0]   wc_q;
  logic               done_q;
  logic               ill_q;
  logic               wrap_q;

  logic               fifo_empty;
  logic               illegal_in;
  logic               accept;
  logic               push;
  logic               pop;
  logic [15:0]        packed_word;

  // Arithmetic class carries two source registers; every other legal class
  // carries the 5-bit address/immediate in the low bits.
  function automatic logic [15:0] pack_fields(input logic [4:0] op,
                                              input logic [2:0] rd,
                                              input logic [2:0] rs1,
                                              input logic [2:0] rs2,
                                              input logic [4:0] addr);
    if (op[4:2] == 3'b010) return {op, rd, rs2, rs1, 2'b00};
    return {op, rd, 3'b000, addr};
  endfunction

  assign fifo_empty     = (cnt_q == '0);
  assign illegal_in     = (bus.in_opcode[4:3] == 2'b11);
  assign bus.in_ready   = (state_q == LOAD) && (cnt_q != FULL_CNT);
  assign accept         = bus.in_valid && bus.in_ready;
  assign push           = accept && !illegal_in;
  assign busy           = (state_q != IDLE);
  assign bus.imem_we    = !fifo_empty && busy;
  assign pop            = bus.imem_we && bus.imem_ready;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];
  assign packed_word    = pack_fields(bus.in_opcode, bus.in_rd, bus.in_rs1,
                                      bus.in_rs2, bus.in_address);
  assign done           = done_q;
  assign word_count     = wc_q;
  assign err_illegal    = ill_q;
  assign err_wrap       = wrap_q;

  // FIFO occupancy next state: simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Packed-word storage; contents are meaningless while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= packed_word;
  end

  // Session FSM, FIFO pointers, write address, counters and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wc_q     <= '0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        addr_q   <= addr_q + 1'b1;
        if (wc_q != WC_MAX)      wc_q   <= wc_q + 1'b1;
        if (addr_q == ADDR_LAST) wrap_q <= 1'b1;
      end
      if (accept && illegal_in) ill_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            addr_q  <= base_addr;
            wc_q    <= '0;
            ill_q   <= 1'b0;
            wrap_q  <= 1'b0;
          end
        end
        LOAD: begin
          if (finish) state_q <= DRAIN;
        end
        DRAIN: begin
          // An empty FIFO means the last write has already been accepted.
          if (fifo_empty) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: a driver issues field bundles
// and pushes the expected {address, word} into a scoreboard queue; a monitor
// pops and compares on every accepted memory write.
module tb_instr_encoder_loader;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          finish = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, err_illegal, err_wrap;
  logic [AW:0]   word_count;

  instr_encoder_loader_if #(.IMEM_AW(AW)) bus();

  instr_encoder_loader #(.IMEM_AW(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .finish(finish), .bus(bus), .busy(busy), .done(done),
    .word_count(word_count), .err_illegal(err_illegal), .err_wrap(err_wrap)
  );

  always #5 clk = ~clk;

  int            tests = 0;
  int            fails = 0;
  logic [20:0]   exp_q[$];
  logic [20:0]   mon_e;
  int            model_addr = 0;
  int            model_n = 0;
  bit            exp_ill = 0;
  bit            exp_wrap = 0;
  int            accepted = 0;
  int            done_seen = 0;
  int            rdy_mode = 0;
  logic [AW-1:0] last_addr = '0;
  logic [15:0]   last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory backpressure: 0 = always ready, 1 = random, 2 = stalled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.imem_ready = 1'b1;
      1:       bus.imem_ready = 1'(($urandom_range(0, 1)));
      default: bus.imem_ready = 1'b0;
    endcase
  end

  // Monitor: every accepted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (done) done_seen++;
    if (bus.imem_we === 1'b1 && bus.imem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.imem_addr), 32'(mon_e[20:16]));
        check("wr_data", 32'(bus.imem_wdata), 32'(mon_e[15:0]));
      end
      last_addr = bus.imem_addr;
      last_data = bus.imem_wdata;
    end
  end

  // Reference model: the instruction format written out as field weights.
  function automatic void model_accept(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [4:0] ad);
    int cls = int'(op) / 4;
    int w;
    accepted++;
    if (cls >= 6) begin
      exp_ill = 1;
      return;
    end
    if (cls == 2) w = int'(op) * 2048 + int'(rd) * 256 + int'(rs2) * 32 + int'(rs1) * 4;
    else          w = int'(op) * 2048 + int'(rd) * 256 + int'(ad);
    exp_q.push_back({5'(model_addr), 16'(w)});
    if (model_addr == 31) exp_wrap = 1;
    model_addr = (model_addr + 1) % 32;
    model_n++;
  endfunction

  task automatic send(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic [4:0] ad);
    int n = 0;
    bus.in_valid   = 1'b1;
    bus.in_opcode  = op;
    bus.in_rd      = rd;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_address = ad;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready %0b after %0d cycles, expected 1", bus.in_ready, n);
      bus.in_valid = 1'b0;
      return;
    end
    model_accept(op, rd, rs1, rs2, ad);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_legal();
    logic [4:0] op;
    op = 5'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
    send(op, 3'($urandom), 3'($urandom), 3'($urandom), 5'($urandom));
  endtask

  task automatic start_session(input int base);
    base_addr  = AW'(base);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    model_addr = base;
    model_n    = 0;
    exp_ill    = 0;
    exp_wrap   = 0;
    accepted   = 0;
  endtask

  task automatic finish_session();
    int n = 0;
    int d0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    d0 = done_seen;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("done_pulse", 32'(done), 32'd1);
    check("word_count", 32'(word_count), 32'((model_n > 32) ? 32 : model_n));
    check("err_illegal", 32'(err_illegal), 32'(exp_ill));
    check("err_wrap", 32'(err_wrap), 32'(exp_wrap));
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    tick();
    check("done_once", 32'(done_seen - d0), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err_illegal"}, 32'(err_illegal), 32'd0);
    check({tag, "_err_wrap"}, 32'(err_wrap), 32'd0);
    check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    int d0;
    bus.in_valid   = 1'b0;
    bus.in_opcode  = '0;
    bus.in_rd      = '0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_address = '0;
    #12;
    check_reset_values("rst");
    @(negedge clk) rst_n = 1'b1;
    tick();

    // finish in IDLE is ignored
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick();
    check("finish_idle_busy", 32'(busy), 32'd0);

    // single ADD at address 0
    start_session(0);
    send(5'b01000, 3'd1, 3'd3, 3'd2, 5'd0);
    finish_session();
    check("add_addr", 32'(last_addr), 32'd0);
    check("add_data", 32'(last_data), 32'h414C);

    // LOAD then JMP from base 4, with an ignored start mid-session
    start_session(4);
    send(5'b00000, 3'd5, 3'd0, 3'd0, 5'h1F);
    base_addr = 5'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    send(5'b10000, 3'd0, 3'd0, 3'd0, 5'h0A);
    finish_session();
    check("jmp_addr", 32'(last_addr), 32'd5);
    check("jmp_data", 32'(last_data), 32'h800A);

    // memory stalled while six bundles are offered
    rdy_mode = 2;
    start_session(0);
    fork
      begin
        for (int i = 0; i < 6; i++) send_legal();
      end
      begin
        repeat (10) tick();
        check("bp_accepted", 32'(accepted), 32'd4);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_imem_we", 32'(bus.imem_we), 32'd1);
        rdy_mode = 0;
      end
    join
    finish_session();

    // illegal class between two legal words
    start_session(8);
    send_legal();
    send(5'b11000, 3'd2, 3'd1, 3'd1, 5'd3);
    send_legal();
    finish_session();
    check("ill_accepted", 32'(accepted), 32'd3);

    // address wrap, then the next start clears the sticky flag
    start_session(30);
    for (int i = 0; i < 3; i++) send_legal();
    finish_session();
    check("wrap_set", 32'(err_wrap), 32'd1);
    start_session(0);
    check("wrap_cleared", 32'(err_wrap), 32'd0);
    check("ill_cleared", 32'(err_illegal), 32'd0);
    send_legal();
    finish_session();

    // word_count saturation
    start_session(0);
    for (int i = 0; i < 34; i++) send_legal();
    finish_session();

    // randomized sessions with random backpressure and illegal opcodes
    rdy_mode = 1;
    for (int s = 0; s < 6; s++) begin
      start_session(int'($urandom_range(0, 31)));
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
        send(5'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 5'($urandom));
        repeat ($urandom_range(0, 2)) tick();
      end
      finish_session();
    end

    // reset asserted in DRAIN with words still queued
    rdy_mode = 2;
    start_session(0);
    for (int i = 0; i < 3; i++) send_legal();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick();
    check("drain_busy", 32'(busy), 32'd1);
    d0 = done_seen;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    rdy_mode = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("midrst_no_we", 32'(bus.imem_we), 32'd0);
    check("midrst_no_done", 32'(done_seen - d0), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
